arbitrate: RTL and testbench

Round-robin arbiter that shares one `W`-bit stream sink between `N` stream sources using the codebase stb/ack handshake. Each source may hold its grant for up to `L` consecutive beats (burst lock), so short multi-word groups stay contiguous. The output is registered, giving one cycle of latency at full throughput. It is the merge-side counterpart to the `seperate` splitter and sits in front of any shared datapath resource.

---
 rtl/arbitrate.sv | 113 +++++++++++
 tb/tb_arbitrate.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitrate.sv
// Round-robin stream arbiter: merges N stb/ack sources into one registered sink port,
// letting a source keep the grant for up to L consecutive beats while it keeps requesting.
module arbitrate #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4,
    parameter int unsigned L = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              s_stb,
    input  logic [N-1:0][W-1:0]       s_dat,
    output logic [N-1:0]              s_ack,
    output logic                      m_stb,
    output logic [W-1:0]              m_dat,
    input  logic                      m_ack,
    output logic [$clog2(N)-1:0]      m_sel
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(L) + 1;

    logic          m_stb_q, m_stb_d;
    logic [W-1:0]  m_dat_q, m_dat_d;
    logic [SW-1:0] m_sel_q, m_sel_d;
    logic [SW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          take;
    logic          locked;
    logic          accept;
    logic          gnt_valid;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] start;
    int unsigned   idx;

    assign take   = ~m_stb_q | m_ack;
    assign accept = take & gnt_valid & ~rst;

    // Stay on the locked source while it still requests, otherwise rotate past it.
    always_comb begin
        locked = (cnt_q != '0) && s_stb[last_q];
        if (locked) begin
            start = last_q;
        end else if (last_q == SW'(N - 1)) begin
            start = '0;
        end else begin
            start = last_q + SW'(1);
        end
    end

    // First requester at or after start, wrapping modulo N.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(start) + k) % N;
            if (!gnt_valid && s_stb[SW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(idx);
            end
        end
    end

    always_comb begin
        s_ack = '0;
        if (accept) begin
            s_ack[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        m_stb_d = m_stb_q;
        m_dat_d = m_dat_q;
        m_sel_d = m_sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (take) begin
            m_stb_d = gnt_valid;
            if (gnt_valid) begin
                m_dat_d = s_dat[gnt_idx];
                m_sel_d = gnt_idx;
                last_d  = gnt_idx;
                if (gnt_idx == last_q && cnt_q != '0) begin
                    cnt_d = (32'(cnt_q) + 32'd1 == L) ? '0 : cnt_q + CW'(1);
                end else begin
                    cnt_d = (L == 1) ? '0 : CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_stb_q <= 1'b0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            last_q  <= SW'(N - 1);
            cnt_q   <= '0;
        end else begin
            m_stb_q <= m_stb_d;
            m_dat_q <= m_dat_d;
            m_sel_q <= m_sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_stb = m_stb_q;
    assign m_dat = m_dat_q;
    assign m_sel = m_sel_q;

endmodule

// File: tb/tb_arbitrate.sv
// Bench for arbitrate: three instances (L = 1, 2, 4) checked every cycle against a
// per-cycle reference model, plus directed scenarios with fixed expected values.
module tb_arbitrate;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       s_stb [3];
    logic [3:0][7:0]  s_dat [3];
    logic [3:0]       s_ack [3];
    logic             m_stb [3];
    logic [7:0]       m_dat [3];
    logic             m_ack [3];
    logic [1:0]       m_sel [3];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one set per instance.
    int         md_last [3];
    int         md_cnt  [3];
    bit         md_stb  [3];
    int         md_dat  [3];
    int         md_sel  [3];
    logic [3:0] ack_seen [3];

    always #5 clk = ~clk;

    arbitrate #(.W(8), .N(4), .L(1)) u_l1 (
        .clk(clk), .rst(rst), .s_stb(s_stb[0]), .s_dat(s_dat[0]), .s_ack(s_ack[0]),
        .m_stb(m_stb[0]), .m_dat(m_dat[0]), .m_ack(m_ack[0]), .m_sel(m_sel[0]));
    arbitrate #(.W(8), .N(4), .L(2)) u_l2 (
        .clk(clk), .rst(rst), .s_stb(s_stb[1]), .s_dat(s_dat[1]), .s_ack(s_ack[1]),
        .m_stb(m_stb[1]), .m_dat(m_dat[1]), .m_ack(m_ack[1]), .m_sel(m_sel[1]));
    arbitrate #(.W(8), .N(4), .L(4)) u_l4 (
        .clk(clk), .rst(rst), .s_stb(s_stb[2]), .s_dat(s_dat[2]), .s_ack(s_ack[2]),
        .m_stb(m_stb[2]), .m_dat(m_dat[2]), .m_ack(m_ack[2]), .m_sel(m_sel[2]));

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lval(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic void model_reset(input int d);
        md_last[d] = 3;
        md_cnt[d]  = 0;
        md_stb[d]  = 1'b0;
        md_dat[d]  = 0;
        md_sel[d]  = 0;
    endfunction

    // Scan requesters in rotating order from the search start; -1 when nobody asks.
    function automatic int model_grant(input int d);
        int first;
        first = (md_cnt[d] != 0 && s_stb[d][md_last[d]]) ? md_last[d] : (md_last[d] + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            if (s_stb[d][(first + k) % 4]) return (first + k) % 4;
        end
        return -1;
    endfunction

    // One clock: check acks and outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int         g    [3];
        bit         take [3];
        logic [3:0] exp_ack;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            g[d]    = model_grant(d);
            take[d] = !md_stb[d] || m_ack[d];
            exp_ack = (!rst && take[d] && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0000;
            ack_seen[d] = s_ack[d];
            chk($sformatf("s_ack[L%0d]", lval(d)), int'(s_ack[d]), int'(exp_ack));
            chk($sformatf("m_stb[L%0d]", lval(d)), int'(m_stb[d]), int'(md_stb[d]));
            chk($sformatf("m_dat[L%0d]", lval(d)), int'(m_dat[d]), md_dat[d]);
            chk($sformatf("m_sel[L%0d]", lval(d)), int'(m_sel[d]), md_sel[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                model_reset(d);
            end else if (take[d]) begin
                if (g[d] >= 0) begin
                    md_stb[d] = 1'b1;
                    md_dat[d] = int'(s_dat[d][g[d]]);
                    md_sel[d] = g[d];
                    if (g[d] == md_last[d] && md_cnt[d] != 0)
                        md_cnt[d] = (md_cnt[d] + 1 == lval(d)) ? 0 : md_cnt[d] + 1;
                    else
                        md_cnt[d] = (lval(d) == 1) ? 0 : 1;
                    md_last[d] = g[d];
                end else begin
                    md_stb[d] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            s_stb[d] = 4'b0000;
            m_ack[d] = 1'b1;
        end
    endtask

    task automatic reset_all();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_m_stb", int'(m_stb[d]), 0);
            chk("rst_m_dat", int'(m_dat[d]), 0);
            chk("rst_m_sel", int'(m_sel[d]), 0);
        end
    endtask

    // Sources keep stb/data until acked; then randomly issue a new beat or go idle.
    task automatic rand_sources();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (!s_stb[d][i] || ack_seen[d][i]) begin
                    s_stb[d][i] = ($urandom_range(0, 2) != 0);
                    s_dat[d][i] = 8'($urandom);
                end
            end
            m_ack[d] = ($urandom_range(0, 3) != 0);
        end
        rst = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            s_stb[d]    = 4'b0000;
            s_dat[d]    = '0;
            m_ack[d]    = 1'b1;
            ack_seen[d] = 4'b0000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) model_reset(d);
        rst = 1'b0;

        // Single beat from source 1, L = 1.
        reset_all();
        s_stb[0] = 4'b0010;
        s_dat[0][1] = 8'h5A;
        cycle();
        chk("single_ack", int'(ack_seen[0]), 4'b0010);
        chk("single_stb", int'(m_stb[0]), 1);
        chk("single_dat", int'(m_dat[0]), 8'h5A);
        chk("single_sel", int'(m_sel[0]), 1);
        s_stb[0] = 4'b0000;
        cycle();
        chk("single_drain", int'(m_stb[0]), 0);

        // All sources requesting: L = 1 rotates every beat, L = 2 pairs beats.
        reset_all();
        for (int i = 0; i < 4; i++) begin
            s_dat[0][i] = 8'(8'h10 + i);
            s_dat[1][i] = 8'(8'h20 + i);
        end
        s_stb[0] = 4'b1111;
        s_stb[1] = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c < 6) begin
                chk("rr_l1_sel", int'(m_sel[0]), c % 4);
                chk("rr_l1_dat", int'(m_dat[0]), 8'h10 + c % 4);
            end
            chk("rr_l2_sel", int'(m_sel[1]), (c / 2) % 4);
            chk("rr_l2_dat", int'(m_dat[1]), 8'h20 + (c / 2) % 4);
        end

        // Backpressure holds the output and blocks all acks.
        reset_all();
        s_stb[0] = 4'b0001;
        s_dat[0][0] = 8'hA3;
        cycle();
        chk("bp_load", int'(m_dat[0]), 8'hA3);
        m_ack[0] = 1'b0;
        s_stb[0] = 4'b0101;
        s_dat[0][0] = 8'h11;
        s_dat[0][2] = 8'h22;
        repeat (5) begin
            cycle();
            chk("bp_hold_dat", int'(m_dat[0]), 8'hA3);
            chk("bp_hold_stb", int'(m_stb[0]), 1);
            chk("bp_hold_ack", int'(ack_seen[0]), 0);
        end
        m_ack[0] = 1'b1;
        cycle();
        chk("bp_rel_ack", int'(ack_seen[0]), 4'b0100);
        chk("bp_rel_dat", int'(m_dat[0]), 8'h22);
        chk("bp_rel_sel", int'(m_sel[0]), 2);
        s_stb[0] = 4'b0001;
        cycle();
        chk("bp_next_ack", int'(ack_seen[0]), 4'b0001);
        chk("bp_next_stb", int'(m_stb[0]), 1);
        chk("bp_next_dat", int'(m_dat[0]), 8'h11);

        // Lock break with L = 4: locked source drops stb, next source served at once.
        reset_all();
        s_stb[2] = 4'b0100;
        s_dat[2][2] = 8'h42;
        cycle();
        chk("lock_first_ack", int'(ack_seen[2]), 4'b0100);
        chk("lock_first_sel", int'(m_sel[2]), 2);
        s_stb[2] = 4'b1000;
        s_dat[2][3] = 8'h43;
        cycle();
        chk("lock_break_ack", int'(ack_seen[2]), 4'b1000);
        chk("lock_break_sel", int'(m_sel[2]), 3);
        chk("lock_break_dat", int'(m_dat[2]), 8'h43);

        // Reset in the middle of an L = 2 burst.
        reset_all();
        s_stb[1] = 4'b0010;
        s_dat[1][1] = 8'h71;
        cycle();
        chk("mid_rst_first", int'(m_sel[1]), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_ack", int'(ack_seen[1]), 0);
        chk("mid_rst_stb", int'(m_stb[1]), 0);
        s_stb[1] = 4'b0011;
        s_dat[1][0] = 8'h70;
        cycle();
        chk("mid_rst_grant", int'(ack_seen[1]), 4'b0001);
        chk("mid_rst_sel", int'(m_sel[1]), 0);

        // Randomized traffic, stalls and occasional resets against the model.
        idle_all();
        for (int c = 0; c < 2000; c++) begin
            rand_sources();
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
